// File: rtl/mul_pkg.sv
// Shared types for the sequential multiplier and the divider wrapper.
// Build option: MUL_SIGNED_EN selects two's-complement operands in mul_seq.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } mul_flags_t;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditional add of mcand into acc, then
// {carry,acc,mplr} shifted right by one so no carry bit is lost.
module mul_step #(
  parameter int M = 4
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] mplr,
  input  logic [M-1:0] mcand,
  output logic [M-1:0] acc_nx,
  output logic [M-1:0] mplr_nx
);

  logic [M:0] sum;

  always_comb begin
    sum     = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_nx  = sum[M:1];
    mplr_nx = {sum[0], mplr[M-1:1]};
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative M x M -> 2M multiplier behind a start/busy/done handshake.
// Build option: define MUL_SIGNED_EN for two's-complement operands.
module mul_seq
  import mul_pkg::*;
#(
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   A,
  input  logic [M-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] P,
  output logic           C,
  output logic           N,
  output logic           V,
  output logic           Z
);

  localparam int CW = $clog2(M);

  mul_state_t      state;
  logic [M-1:0]    mcand, mplr, acc;
  logic [CW-1:0]   cnt;
  logic [M-1:0]    acc_nx, mplr_nx;
  logic [M-1:0]    a_in, b_in;
  logic [2*M-1:0]  mag, res;
  mul_flags_t      flg, flg_nx;

  mul_step #(.M(M)) u_step (
    .acc     (acc),
    .mplr    (mplr),
    .mcand   (mcand),
    .acc_nx  (acc_nx),
    .mplr_nx (mplr_nx)
  );

`ifdef MUL_SIGNED_EN
  logic sgn;

  // Magnitudes stay M-bit unsigned so -2^(M-1) maps cleanly to 2^(M-1).
  always_comb begin
    a_in = A[M-1] ? -A : A;
    b_in = B[M-1] ? -B : B;
  end
`else
  always_comb begin
    a_in = A;
    b_in = B;
  end
`endif

  always_comb begin
    mag    = {acc_nx, mplr_nx};
    flg_nx = '0;
`ifdef MUL_SIGNED_EN
    res      = sgn ? -mag : mag;
    flg_nx.v = ~((&res[2*M-1:M-1]) | ~(|res[2*M-1:M-1]));
`else
    res      = mag;
    flg_nx.v = |res[2*M-1:M];
`endif
    flg_nx.c = |res[2*M-1:M];
    flg_nx.n = res[2*M-1];
    flg_nx.z = ~|res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      flg   <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
`ifdef MUL_SIGNED_EN
      sgn   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // The DONE cycle doubles as an accept slot, so a held start chains ops.
          done <= 1'b0;
          if (start) begin
            mcand <= a_in;
            mplr  <= b_in;
            acc   <= '0;
            cnt   <= CW'(M-1);
            busy  <= 1'b1;
            state <= RUN;
`ifdef MUL_SIGNED_EN
            sgn   <= A[M-1] ^ B[M-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc  <= acc_nx;
          mplr <= mplr_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            P     <= res;
            flg   <= flg_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign C = flg.c;
  assign N = flg.n;
  assign V = flg.v;
  assign Z = flg.z;

endmodule
